// File: rtl/sr_prog_loader_if.sv
// Byte stream into the program loader: valid/ready handshake carrying one byte per transfer.
interface sr_prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sr_prog_loader.sv
// Program loader for the schoolRISCV instruction memory: takes a length-prefixed byte stream,
// packs little-endian words into the RAM write port and holds the CPU in reset until done.
module sr_prog_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  sr_prog_loader_if.slave   strm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERR} state_t;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            state;
  logic [7:0]        lenLo;
  logic [ADDR_W-1:0] wordIdx;
  logic [ADDR_W-1:0] lastIdx;
  logic [1:0]        byteCnt;
  logic [23:0]       partial;

  logic        xfer;
  logic [16:0] lenFull;
  logic [16:0] lenM1;

  assign xfer    = strm.in_valid & strm.in_ready;
  assign lenFull = {1'b0, strm.in_data, lenLo};
  assign lenM1   = lenFull - 17'd1;

  // NOTE: every output is a register updated together with the state, so all
  // assignments here are non-blocking and later ones in the same cycle win.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      lenLo         <= '0;
      wordIdx       <= '0;
      lastIdx       <= '0;
      byteCnt       <= '0;
      partial       <= '0;
      strm.in_ready <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_rst       <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          // The CPU leaves reset one cycle after entering DONE, i.e. after the final write.
          if (state == DONE) cpu_rst <= 1'b0;
          if (start) begin
            state         <= LEN0;
            strm.in_ready <= 1'b1;
            busy          <= 1'b1;
            cpu_rst       <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
            byteCnt       <= '0;
            wordIdx       <= '0;
          end
        end

        LEN0: begin
          if (xfer) begin
            lenLo <= strm.in_data;
            state <= LEN1;
          end
        end

        LEN1: begin
          if (xfer) begin
            if (lenFull == 17'd0) begin
              state         <= DONE;
              strm.in_ready <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else if (lenFull > DEPTH) begin
              state         <= ERR;
              strm.in_ready <= 1'b0;
              busy          <= 1'b0;
              err           <= 1'b1;
            end else begin
              state   <= DATA;
              lastIdx <= lenM1[ADDR_W-1:0];
            end
          end
        end

        DATA: begin
          if (xfer) begin
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= wordIdx;
              mem_wdata <= {strm.in_data, partial};
              // For a full-depth load this wraps to zero after the last write, harmlessly.
              wordIdx   <= wordIdx + 1'b1;
              if (wordIdx == lastIdx) begin
                state         <= DONE;
                strm.in_ready <= 1'b0;
                busy          <= 1'b0;
                done          <= 1'b1;
              end
            end else begin
              partial[{byteCnt, 3'b000} +: 8] <= strm.in_data;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
